// File: rtl/uart_tx_mmio_if.sv
// ============================================================================
//  Module      : uart_tx_mmio_if
//  Description : Core data-bus view of the memory-mapped UART transmitter.
//                The core drives the store/address/data signals. The
//                peripheral returns its address decode and read data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_mmio_if;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic        hit;
    logic [31:0] rd_data;

    modport master (
        output MemWrite,
        output Mem_WrAddr,
        output Mem_WrData,
        input  hit,
        input  rd_data
    );

    modport slave (
        input  MemWrite,
        input  Mem_WrAddr,
        input  Mem_WrData,
        output hit,
        output rd_data
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ============================================================================
//  Module      : uart_tx_mmio
//  Description : Memory-mapped 8N1 UART transmitter with a small TX FIFO.
//                Stores to TXDATA queue bytes. STATUS is a combinational read
//                port: full, empty, busy, sticky overflow and count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_mmio_if.slave   bus,
    output logic            tx
);

    localparam int C_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W  = C_PTR_W + 1;
    localparam int C_BCNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [C_BCNT_W-1:0] C_BCNT_LAST = C_BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_FULL  = C_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [C_BCNT_W-1:0]   r_bcnt;
    logic [C_BCNT_W-1:0]   w_bcnt_nxt;
    logic [2:0]            r_bidx;
    logic [2:0]            w_bidx_nxt;
    logic [7:0]            r_shreg;
    logic [7:0]            w_shreg_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;

    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_CNT_W-1:0]    r_count;
    logic                  r_overflow;

    logic                  w_hit;
    logic [1:0]            w_offset;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_ov_set;
    logic                  w_ov_clr;
    logic                  w_bit_end;
    logic [31:0]           w_count_ext;
    logic [2:0]            w_cnt_disp;
    logic                  w_unused_bits;

    // Address decode and FIFO handshake. A pop can only happen from IDLE.
    // This frees a slot on the same edge, so a store to a full FIFO is
    // accepted when it coincides with a pop.
    assign w_hit      = (bus.Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
    assign w_offset   = bus.Mem_WrAddr[3:2];
    assign w_full     = (r_count == C_CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_pop      = (r_state == IDLE) && !w_empty;
    assign w_push_req = bus.MemWrite && w_hit && (w_offset == 2'd0);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ov_set   = w_push_req && w_full && !w_pop;
    assign w_ov_clr   = bus.MemWrite && w_hit && (w_offset == 2'd1);
    assign w_bit_end  = (r_bcnt == C_BCNT_LAST);

    assign w_count_ext   = 32'(r_count);
    assign w_cnt_disp    = (w_count_ext > 32'd7) ? 3'd7 : w_count_ext[2:0];
    assign w_unused_bits = ^{bus.Mem_WrData[31:8], bus.Mem_WrAddr[1:0]};

    assign bus.hit = w_hit;
    assign tx      = r_tx;

    // Register read mux: only STATUS returns non-zero data.
    always_comb begin
        bus.rd_data = 32'd0;
        if (w_hit && (w_offset == 2'd1)) begin
            bus.rd_data = {25'd0, w_cnt_disp, r_overflow, (r_state != IDLE), w_empty, w_full};
        end
    end

    // FIFO storage: written only on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.Mem_WrData[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_ov_set) begin
                r_overflow <= 1'b1;
            end else if (w_ov_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM state register. tx is registered so the line never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_bidx  <= '0;
            r_shreg <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_bidx  <= w_bidx_nxt;
            r_shreg <= w_shreg_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Transmit FSM next state. The next line level is derived from the next
    // state, so tx is aligned with the state it belongs to.
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_bidx_nxt  = r_bidx;
        w_shreg_nxt = r_shreg;
        w_tx_nxt    = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_shreg_nxt = r_mem[r_rd_ptr];
                    w_bcnt_nxt  = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_bcnt_nxt  = '0;
                    w_bidx_nxt  = '0;
                    w_state_nxt = DATA;
                end else begin
                    w_bcnt_nxt = r_bcnt + C_BCNT_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_bcnt_nxt  = '0;
                    w_shreg_nxt = {1'b0, r_shreg[7:1]};
                    if (r_bidx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bidx_nxt = r_bidx + 3'd1;
                    end
                end else begin
                    w_bcnt_nxt = r_bcnt + C_BCNT_W'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_bcnt_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_bcnt_nxt = r_bcnt + C_BCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shreg_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the CPU data bus, downstream of the single-cycle core. It decodes the core's store and load accesses (MemWrite, Mem_WrAddr, Mem_WrData) and queues bytes in a small FIFO. It serialises each byte 8N1 on a tx pin, LSB first. A combinational read port returns status so firmware can poll before storing; the top-level ReadData mux selects it when hit is high.

Parameters:
BASE_ADDR, 32'h0000_0400, word-aligned base of the 16-byte register window
CLKS_PER_BIT, 16, clock cycles per UART bit (minimum 2)
FIFO_DEPTH, 4, TX FIFO entries (power of 2, minimum 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
MemWrite  input  1  core store strobe
Mem_WrAddr  input  32  core data address (used for both loads and stores)
Mem_WrData  input  32  core store data
hit  output  1  Mem_WrAddr[31:4] == BASE_ADDR[31:4]; combinational
rd_data  output  32  register read data for Mem_WrAddr; combinational, 0 when hit=0
tx  output  1  serial line, idles high

Behaviour:
- Register map (offset = Mem_WrAddr[3:2]; byte offset bits [1:0] ignored):
  - 0x0 TXDATA: store pushes Mem_WrData[7:0]. Reads 0.
  - 0x4 STATUS, read-only except bit 3:
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[6:4] count (entries in FIFO, saturates display at 7). Other bits 0.
    - A store of any value clears overflow.
  - 0x8, 0xC: reads 0, stores ignored.
- Push: MemWrite & hit & offset 0x0 at a rising edge.
  - If not full, the byte is written at wr_ptr, wr_ptr increments (wraps mod FIFO_DEPTH), and count increments.
  - If full and no pop in the same cycle: byte dropped, overflow set to 1.
  - If full and a pop occurs in the same cycle: push accepted, count unchanged.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits. count is log2(FIFO_DEPTH)+1 bits. full = (count == FIFO_DEPTH); empty = (count == 0).
- FSM states: IDLE, START, DATA, STOP. Baud counter bcnt counts 0..CLKS_PER_BIT-1. Bit index bidx is 0..7. shreg is 8 bits.
  - IDLE: tx=1. If !empty: pop the head into shreg, bcnt=0, go to START.
  - START: tx=0. When bcnt == CLKS_PER_BIT-1: bcnt=0, bidx=0, go to DATA. Otherwise bcnt++.
  - DATA: tx=shreg[0]. At end of bit: shift shreg right. If bidx==7 go to STOP, else bidx++.
  - STOP: tx=1. At end of bit go to IDLE. Back-to-back frames therefore have one extra idle cycle between them.
- tx is registered from the FSM and does not glitch.
- Timing:
  - A push at edge N gives empty=0 after N.
  - The pop and the START transition occur at edge N+1; tx falls after N+1.
  - The frame lasts 10*CLKS_PER_BIT cycles, then 1 IDLE cycle.
- Reset (asynchronous, any time, including mid-frame):
  - State=IDLE, tx=1, pointers/count/bcnt/bidx/shreg=0, overflow=0.
  - The FIFO is emptied and any partial frame is abandoned.
  - hit and rd_data remain combinational (status reads empty=1).
- Loads have no side effects. Stores with hit=0 are ignored entirely.

Test Plan:
- Reset, then idle 50 cycles -> tx=1 throughout; STATUS read = 32'h0000_0002 (empty).
- CLKS_PER_BIT=4: store 32'hAB to 0x400 -> tx low 4 cycles starting 1 cycle after the store, then bits 1,1,0,1,0,1,0,1 for 4 cycles each, then high; busy=1 during the 40-cycle frame.
- Store 5 bytes 0x01..0x05 on consecutive cycles while the FSM is busy (FIFO_DEPTH=4) -> 0x05 dropped; STATUS bit3=1, full=1; the line carries 0x01..0x04 in order; a store to 0x404 clears bit3.
- Store to the full FIFO on the same cycle the FSM pops -> byte accepted, count stays 4, no overflow.
- Assert reset mid-DATA on the 3rd bit -> tx=1 immediately, STATUS=0x2, no further frames; a later push transmits correctly.
- Address 0x410 and 0x3FC with MemWrite -> hit=0, no push, rd_data=0; read 0x408 -> hit=1, rd_data=0.
